xspi_flash_responder: RTL and testbench

//  Memory-side responder for the octal SDR command/address/data protocol that memory_interface_controller drives.

---
 rtl/xspi_flash_responder.sv | 187 ++++++++++++++++++
 tb/tb_xspi_flash_responder.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/xspi_flash_responder.sv
// xspi_flash_responder
//   Memory-side model of an octal SDR flash. It decodes the command byte,
//   ADDR_BYTES address bytes (MSB first) and an optional dummy phase from the
//   controller's dq bus. Reads are served from an internal byte array with a
//   toggling read strobe, and write data is stored into the same array.
//
// Ports
//   mem_clk       clock, all logic on the rising edge
//   reset         synchronous active-high reset
//   sclk_en       bus-cycle qualifier; the protocol advances only when high
//   cs_n          chip select, active low; high aborts any transfer
//   dq_in[7:0]    byte from the controller
//   dq_oe_in      controller output enable, used only for conflict detection
//   dummy_cycles  dummy bus cycles between address and read data
//   dq_out[7:0]   read data to the controller
//   dq_oe         responder is driving dq_out/dqs
//   dqs           read strobe, toggles once per read byte
//   illegal_cmd   one-cycle pulse when an unknown opcode is decoded
//   bus_conflict  sticky flag: both sides drove on the same edge
//   busy          high whenever the FSM is not idle
//
// state    | meaning
// IDLE     | cs_n high, waiting for a transfer
// CMD      | selected, waiting for the command bus cycle
// ADDR     | shifting in address bytes
// DUMMY    | counting dummy cycles, preamble on the last one
// RD_DATA  | streaming bytes out of the array
// WR_DATA  | storing bytes into the array
// IGNORE   | unknown opcode, swallow bus cycles until cs_n rises
module xspi_flash_responder #(
  parameter int         MEM_ADDR_WIDTH = 8,
  parameter int         ADDR_BYTES     = 4,
  parameter logic [7:0] RD_CMD         = 8'h0B,
  parameter logic [7:0] WR_CMD         = 8'h02
) (
  input  logic       mem_clk,
  input  logic       reset,
  input  logic       sclk_en,
  input  logic       cs_n,
  input  logic [7:0] dq_in,
  input  logic       dq_oe_in,
  input  logic [4:0] dummy_cycles,
  output logic [7:0] dq_out,
  output logic       dq_oe,
  output logic       dqs,
  output logic       illegal_cmd,
  output logic       bus_conflict,
  output logic       busy
);

  localparam int DEPTH = 1 << MEM_ADDR_WIDTH;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CMD,
    ST_ADDR,
    ST_DUMMY,
    ST_RD_DATA,
    ST_WR_DATA,
    ST_IGNORE
  } state_t;

  state_t                    state;
  logic [7:0]                mem [DEPTH];
  logic [MEM_ADDR_WIDTH-1:0] addr;
  logic [1:0]                byte_cnt;
  logic [4:0]                dummy_cnt;
  logic                      is_read;
  logic                      wr_en;

  // A bus cycle needs cs_n low, so a cs_n rise can never commit a write.
  assign wr_en = !reset && sclk_en && !cs_n && (state == ST_WR_DATA);

  // Array contents survive reset, so the storage lives in its own block.
  always_ff @(posedge mem_clk) begin
    if (wr_en) begin
      mem[addr] <= dq_in;
    end
  end

  always_ff @(posedge mem_clk) begin
    if (reset) begin
      state        <= ST_IDLE;
      addr         <= '0;
      byte_cnt     <= '0;
      dummy_cnt    <= '0;
      is_read      <= 1'b0;
      dq_out       <= '0;
      dq_oe        <= 1'b0;
      dqs          <= 1'b0;
      illegal_cmd  <= 1'b0;
      bus_conflict <= 1'b0;
      busy         <= 1'b0;
    end else begin
      illegal_cmd <= 1'b0;
      if (dq_oe_in && dq_oe) begin
        bus_conflict <= 1'b1;
      end

      if (cs_n) begin
        state <= ST_IDLE;
        busy  <= 1'b0;
        dq_oe <= 1'b0;
        dqs   <= 1'b0;
      end else begin
        busy <= 1'b1;
        case (state)
          // The edge that selects the device is already the command cycle
          // when sclk_en is high.
          ST_IDLE, ST_CMD: begin
            if (sclk_en) begin
              addr     <= '0;
              byte_cnt <= 2'(ADDR_BYTES - 1);
              if (dq_in == RD_CMD) begin
                is_read <= 1'b1;
                state   <= ST_ADDR;
              end else if (dq_in == WR_CMD) begin
                is_read <= 1'b0;
                state   <= ST_ADDR;
              end else begin
                illegal_cmd <= 1'b1;
                state       <= ST_IGNORE;
              end
            end else begin
              state <= ST_CMD;
            end
          end

          ST_ADDR: begin
            if (sclk_en) begin
              addr <= MEM_ADDR_WIDTH'({addr, dq_in});
              if (byte_cnt == 2'd0) begin
                if (!is_read) begin
                  state <= ST_WR_DATA;
                end else if (dummy_cycles == 5'd0) begin
                  state <= ST_RD_DATA;
                end else begin
                  dummy_cnt <= dummy_cycles;
                  state     <= ST_DUMMY;
                end
              end else begin
                byte_cnt <= byte_cnt - 2'd1;
              end
            end
          end

          // Output enable comes up on the final dummy cycle as a preamble
          // with dqs still low.
          ST_DUMMY: begin
            if (sclk_en) begin
              if (dummy_cnt == 5'd1) begin
                dq_oe <= 1'b1;
                state <= ST_RD_DATA;
              end else begin
                dummy_cnt <= dummy_cnt - 5'd1;
              end
            end
          end

          ST_RD_DATA: begin
            if (sclk_en) begin
              dq_out <= mem[addr];
              dqs    <= ~dqs;
              dq_oe  <= 1'b1;
              addr   <= addr + MEM_ADDR_WIDTH'(1);
            end
          end

          ST_WR_DATA: begin
            if (sclk_en) begin
              addr <= addr + MEM_ADDR_WIDTH'(1);
            end
          end

          ST_IGNORE: begin
            state <= ST_IGNORE;
          end

          default: begin
            state <= ST_IDLE;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_xspi_flash_responder.sv
module tb_xspi_flash_responder;

  localparam logic [7:0] RD = 8'h0B;
  localparam logic [7:0] WR = 8'h02;

  logic       mem_clk = 1'b0;
  logic       reset = 1'b0;
  logic       sclk_en = 1'b0;
  logic       cs_n = 1'b1;
  logic [7:0] dq_in = 8'h00;
  logic       dq_oe_in = 1'b0;
  logic [4:0] dummy_cycles = 5'd0;
  logic [7:0] dq_out;
  logic       dq_oe;
  logic       dqs;
  logic       illegal_cmd;
  logic       bus_conflict;
  logic       busy;

  int vec_cnt = 0;
  int err_cnt = 0;

  logic [7:0] model [256];
  logic [7:0] exp_q [$];

  xspi_flash_responder dut (
    .mem_clk      (mem_clk),
    .reset        (reset),
    .sclk_en      (sclk_en),
    .cs_n         (cs_n),
    .dq_in        (dq_in),
    .dq_oe_in     (dq_oe_in),
    .dummy_cycles (dummy_cycles),
    .dq_out       (dq_out),
    .dq_oe        (dq_oe),
    .dqs          (dqs),
    .illegal_cmd  (illegal_cmd),
    .bus_conflict (bus_conflict),
    .busy         (busy)
  );

  always #5 mem_clk = ~mem_clk;

  // Apply one clock with the given inputs, then settle 1 time unit past the edge.
  task automatic cyc(input logic en, input logic cs, input logic [7:0] d);
    sclk_en = en;
    cs_n    = cs;
    dq_in   = d;
    @(posedge mem_clk);
    #1;
  endtask

  task automatic test_reset;
    reset = 1'b1;
    cyc(1'b0, 1'b1, 8'h00);
    cyc(1'b0, 1'b1, 8'h00);
    reset = 1'b0;
    vec_cnt++;
    if ({dq_out, dq_oe, dqs, illegal_cmd, bus_conflict, busy} !== 13'd0) begin
      err_cnt++;
      $display("FAIL reset_outputs: got %b expected 0",
               {dq_out, dq_oe, dqs, illegal_cmd, bus_conflict, busy});
    end
  endtask

  task automatic do_write(input logic [7:0] a, input logic [7:0] d0, input logic [7:0] d1);
    cyc(1'b1, 1'b0, WR);
    vec_cnt++;
    if (busy !== 1'b1) begin
      err_cnt++;
      $display("FAIL write_busy: got %b expected 1", busy);
    end
    cyc(1'b1, 1'b0, 8'h00);
    cyc(1'b1, 1'b0, 8'h00);
    cyc(1'b1, 1'b0, 8'h00);
    cyc(1'b1, 1'b0, a);
    cyc(1'b1, 1'b0, d0);
    vec_cnt++;
    if (dq_oe !== 1'b0) begin
      err_cnt++;
      $display("FAIL write_dq_oe0: got %b expected 0", dq_oe);
    end
    cyc(1'b1, 1'b0, d1);
    vec_cnt++;
    if (dq_oe !== 1'b0) begin
      err_cnt++;
      $display("FAIL write_dq_oe1: got %b expected 0", dq_oe);
    end
    model[a]         = d0;
    model[8'(a + 1)] = d1;
    cyc(1'b0, 1'b1, 8'h00);
  endtask

  task automatic do_read(input logic [7:0] a, input int n, input logic [4:0] dc);
    logic       exp_dqs;
    logic [7:0] exp_b;
    exp_dqs      = 1'b0;
    dummy_cycles = dc;
    cyc(1'b1, 1'b0, RD);
    cyc(1'b1, 1'b0, 8'h00);
    cyc(1'b1, 1'b0, 8'h00);
    cyc(1'b1, 1'b0, 8'h00);
    cyc(1'b1, 1'b0, a);
    vec_cnt++;
    if (dq_oe !== 1'b0) begin
      err_cnt++;
      $display("FAIL read_addr_dq_oe: got %b expected 0", dq_oe);
    end
    for (int k = 1; k <= int'(dc); k++) begin
      cyc(1'b1, 1'b0, 8'h00);
      vec_cnt++;
      if (dq_oe !== (k == int'(dc)) || dqs !== 1'b0) begin
        err_cnt++;
        $display("FAIL read_dummy%0d: got dq_oe=%b dqs=%b expected dq_oe=%b dqs=0",
                 k, dq_oe, dqs, (k == int'(dc)));
      end
    end
    for (int i = 0; i < n; i++) begin
      exp_q.push_back(model[8'(a + 8'(i))]);
      cyc(1'b1, 1'b0, 8'h00);
      exp_b   = exp_q.pop_front();
      exp_dqs = ~exp_dqs;
      vec_cnt++;
      if (dq_out !== exp_b || dqs !== exp_dqs || dq_oe !== 1'b1) begin
        err_cnt++;
        $display("FAIL read_byte%0d @%h: got dq_out=%h dqs=%b dq_oe=%b expected %h %b 1",
                 i, a, dq_out, dqs, dq_oe, exp_b, exp_dqs);
      end
    end
    cyc(1'b0, 1'b1, 8'h00);
    vec_cnt++;
    if (dq_oe !== 1'b0 || dqs !== 1'b0 || busy !== 1'b0) begin
      err_cnt++;
      $display("FAIL read_end: got dq_oe=%b dqs=%b busy=%b expected 0 0 0", dq_oe, dqs, busy);
    end
  endtask

  task automatic test_write_read;
    do_write(8'h10, 8'hA5, 8'h5A);
    do_read(8'h10, 2, 5'd4);
    do_read(8'h10, 2, 5'd1);
  endtask

  task automatic test_wrap;
    do_write(8'hFF, 8'h11, 8'h22);
    do_read(8'hFF, 2, 5'd0);
    do_read(8'h00, 1, 5'd2);
  endtask

  task automatic test_abort;
    cyc(1'b1, 1'b0, RD);
    cyc(1'b1, 1'b0, 8'h00);
    cyc(1'b1, 1'b0, 8'h00);
    cyc(1'b1, 1'b1, 8'h00);
    vec_cnt++;
    if (busy !== 1'b0 || dq_oe !== 1'b0) begin
      err_cnt++;
      $display("FAIL abort_addr: got busy=%b dq_oe=%b expected 0 0", busy, dq_oe);
    end
    // cs_n rise together with sclk_en while in the write data phase
    cyc(1'b1, 1'b0, WR);
    cyc(1'b1, 1'b0, 8'h00);
    cyc(1'b1, 1'b0, 8'h00);
    cyc(1'b1, 1'b0, 8'h00);
    cyc(1'b1, 1'b0, 8'h10);
    cyc(1'b1, 1'b1, 8'hEE);
    vec_cnt++;
    if (busy !== 1'b0) begin
      err_cnt++;
      $display("FAIL abort_write: got busy=%b expected 0", busy);
    end
    do_read(8'h10, 2, 5'd3);
  endtask

  task automatic test_illegal;
    cyc(1'b1, 1'b0, 8'h9F);
    vec_cnt++;
    if (illegal_cmd !== 1'b1 || busy !== 1'b1 || dq_oe !== 1'b0) begin
      err_cnt++;
      $display("FAIL illegal_pulse: got ill=%b busy=%b dq_oe=%b expected 1 1 0",
               illegal_cmd, busy, dq_oe);
    end
    for (int i = 0; i < 6; i++) begin
      cyc(1'b1, 1'b0, 8'h10 + 8'(i));
      vec_cnt++;
      if (illegal_cmd !== 1'b0 || dq_oe !== 1'b0 || busy !== 1'b1) begin
        err_cnt++;
        $display("FAIL illegal_ignore%0d: got ill=%b dq_oe=%b busy=%b expected 0 0 1",
                 i, illegal_cmd, dq_oe, busy);
      end
    end
    cyc(1'b0, 1'b1, 8'h00);
    vec_cnt++;
    if (busy !== 1'b0) begin
      err_cnt++;
      $display("FAIL illegal_end: got busy=%b expected 0", busy);
    end
    do_read(8'h10, 2, 5'd2);
  endtask

  task automatic test_stall_reset;
    logic [7:0] exp_b;
    dummy_cycles = 5'd2;
    cyc(1'b1, 1'b0, RD);
    cyc(1'b1, 1'b0, 8'h00);
    cyc(1'b1, 1'b0, 8'h00);
    cyc(1'b1, 1'b0, 8'h00);
    cyc(1'b1, 1'b0, 8'h10);
    cyc(1'b1, 1'b0, 8'h00);
    cyc(1'b1, 1'b0, 8'h00);
    exp_q.push_back(model[8'h10]);
    cyc(1'b1, 1'b0, 8'h00);
    exp_b = exp_q.pop_front();
    vec_cnt++;
    if (dq_out !== exp_b || dqs !== 1'b1 || dq_oe !== 1'b1) begin
      err_cnt++;
      $display("FAIL stall_first: got %h dqs=%b dq_oe=%b expected %h 1 1", dq_out, dqs, dq_oe, exp_b);
    end
    // Stalled cycle; controller also drives, which must flag a conflict.
    dq_oe_in = 1'b1;
    cyc(1'b0, 1'b0, 8'h00);
    dq_oe_in = 1'b0;
    vec_cnt++;
    if (dq_out !== exp_b || dqs !== 1'b1 || bus_conflict !== 1'b1) begin
      err_cnt++;
      $display("FAIL stall_hold: got %h dqs=%b conflict=%b expected %h 1 1",
               dq_out, dqs, bus_conflict, exp_b);
    end
    cyc(1'b0, 1'b0, 8'h00);
    exp_q.push_back(model[8'h11]);
    cyc(1'b1, 1'b0, 8'h00);
    exp_b = exp_q.pop_front();
    vec_cnt++;
    if (dq_out !== exp_b || dqs !== 1'b0 || bus_conflict !== 1'b1) begin
      err_cnt++;
      $display("FAIL stall_resume: got %h dqs=%b conflict=%b expected %h 0 1",
               dq_out, dqs, bus_conflict, exp_b);
    end
    reset = 1'b1;
    cyc(1'b1, 1'b0, 8'h00);
    reset = 1'b0;
    vec_cnt++;
    if ({dq_out, dq_oe, dqs, illegal_cmd, bus_conflict, busy} !== 13'd0) begin
      err_cnt++;
      $display("FAIL midread_reset: got %b expected 0",
               {dq_out, dq_oe, dqs, illegal_cmd, bus_conflict, busy});
    end
    cyc(1'b0, 1'b1, 8'h00);
    do_read(8'hFF, 2, 5'd0);
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_wrap();
    test_abort();
    test_illegal();
    test_stall_reset();
    vec_cnt++;
    if (exp_q.size() != 0) begin
      err_cnt++;
      $display("FAIL scoreboard_empty: got %0d entries expected 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
